// File: rtl/inv_mix_col_iter.sv
// Iterative AES InvMixColumns engine: one 32-bit column per clock, four per block.
// Optional IMC_FWD_MODE_EN adds a per-block "fwd" input selecting forward MixColumns.
module inv_mix_col_iter (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_state,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_state
`ifdef IMC_FWD_MODE_EN
    ,
    input  logic         fwd
`endif
);

    localparam int unsigned DATA_W = 128;
    localparam int unsigned COL_W  = 32;
    localparam int unsigned BYTE_W = 8;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]        state, state_nxt;
    logic [1:0]        col, col_nxt;
    logic [DATA_W-1:0] work, work_nxt;
    logic [COL_W-1:0]  col_in, col_out;
`ifdef IMC_FWD_MODE_EN
    logic              mode, mode_nxt;
`endif

    function automatic logic [BYTE_W-1:0] xtime(input logic [BYTE_W-1:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1B : 8'h00);
    endfunction

    // Multiply by a 4-bit constant k as a sum of x, x2, x4, x8.
    function automatic logic [BYTE_W-1:0] gm(input logic [BYTE_W-1:0] x, input logic [3:0] k);
        logic [BYTE_W-1:0] x2, x4, x8;
        x2 = xtime(x);
        x4 = xtime(x2);
        x8 = xtime(x4);
        return (k[3] ? x8 : 8'h00) ^ (k[2] ? x4 : 8'h00) ^
               (k[1] ? x2 : 8'h00) ^ (k[0] ? x  : 8'h00);
    endfunction

    function automatic logic [COL_W-1:0] inv_col(input logic [COL_W-1:0] a);
        logic [BYTE_W-1:0] a0, a1, a2, a3;
        {a0, a1, a2, a3} = a;
        return {gm(a0, 4'hE) ^ gm(a1, 4'hB) ^ gm(a2, 4'hD) ^ gm(a3, 4'h9),
                gm(a0, 4'h9) ^ gm(a1, 4'hE) ^ gm(a2, 4'hB) ^ gm(a3, 4'hD),
                gm(a0, 4'hD) ^ gm(a1, 4'h9) ^ gm(a2, 4'hE) ^ gm(a3, 4'hB),
                gm(a0, 4'hB) ^ gm(a1, 4'hD) ^ gm(a2, 4'h9) ^ gm(a3, 4'hE)};
    endfunction

`ifdef IMC_FWD_MODE_EN
    function automatic logic [COL_W-1:0] fwd_col(input logic [COL_W-1:0] a);
        logic [BYTE_W-1:0] a0, a1, a2, a3;
        {a0, a1, a2, a3} = a;
        return {gm(a0, 4'h2) ^ gm(a1, 4'h3) ^ a2 ^ a3,
                a0 ^ gm(a1, 4'h2) ^ gm(a2, 4'h3) ^ a3,
                a0 ^ a1 ^ gm(a2, 4'h2) ^ gm(a3, 4'h3),
                gm(a0, 4'h3) ^ a1 ^ a2 ^ gm(a3, 4'h2)};
    endfunction
`endif

    assign in_ready  = (state == ST_IDLE);
    assign out_state = work;

    // Next-state, column select and work-register update.
    always_comb begin
        state_nxt = state;
        col_nxt   = col;
        work_nxt  = work;
`ifdef IMC_FWD_MODE_EN
        mode_nxt  = mode;
`endif
        case (col)
            2'd0:    col_in = work[127:96];
            2'd1:    col_in = work[95:64];
            2'd2:    col_in = work[63:32];
            default: col_in = work[31:0];
        endcase
`ifdef IMC_FWD_MODE_EN
        col_out = mode ? fwd_col(col_in) : inv_col(col_in);
`else
        col_out = inv_col(col_in);
`endif
        case (state)
            ST_IDLE: begin
                if (in_valid) begin
                    work_nxt  = in_state;
                    col_nxt   = 2'd0;
                    state_nxt = ST_BUSY;
`ifdef IMC_FWD_MODE_EN
                    mode_nxt  = fwd;
`endif
                end
            end
            ST_BUSY: begin
                case (col)
                    2'd0:    work_nxt[127:96] = col_out;
                    2'd1:    work_nxt[95:64]  = col_out;
                    2'd2:    work_nxt[63:32]  = col_out;
                    default: work_nxt[31:0]   = col_out;
                endcase
                col_nxt = col + 2'd1;
                if (col == 2'd3) state_nxt = ST_DONE;
            end
            ST_DONE: begin
                if (out_ready) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            col       <= 2'd0;
            work      <= '0;
            out_valid <= 1'b0;
`ifdef IMC_FWD_MODE_EN
            mode      <= 1'b0;
`endif
        end else begin
            state     <= state_nxt;
            col       <= col_nxt;
            work      <= work_nxt;
            out_valid <= (state_nxt == ST_DONE);
`ifdef IMC_FWD_MODE_EN
            mode      <= mode_nxt;
`endif
        end
    end

endmodule

// File: tb/tb_inv_mix_col_iter.sv
// Directed bench for inv_mix_col_iter: vector table plus backpressure, mid-block
// reset, back-to-back and (with IMC_FWD_MODE_EN) forward round-trip sequences.
module tb_inv_mix_col_iter;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_state;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_state;
`ifdef IMC_FWD_MODE_EN
    logic         fwd;
`endif

    int n_cmp  = 0;
    int n_fail = 0;

    typedef struct {
        logic [127:0] din;
        logic [127:0] dout;
    } vec_t;

    vec_t vecs[7];

    inv_mix_col_iter dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_state  (in_state),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_state (out_state)
`ifdef IMC_FWD_MODE_EN
        ,
        .fwd       (fwd)
`endif
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Send one block, check latency and result, then retire it with out_ready.
    task automatic run_block(input string name, input logic [127:0] din, input logic [127:0] exp);
        int lat;
        check({name, " in_ready idle"}, 128'(in_ready), 128'(1));
        in_valid = 1'b1;
        in_state = din;
        step();
        in_valid = 1'b0;
        in_state = '0;
        check({name, " in_ready busy"}, 128'(in_ready), 128'(0));
        lat = 0;
        while (!out_valid && lat < 20) begin
            step();
            lat++;
        end
        check({name, " latency"}, 128'(lat), 128'(4));
        check({name, " data"}, out_state, exp);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check({name, " retire"}, 128'({out_valid, in_ready}), 128'(2'b01));
    endtask

    initial begin
        logic [127:0] held;
        logic [127:0] res[$];
        int           acc_cyc[2];
        int           acc_n;

        vecs[0] = '{{32'h8e4da1bc, 96'h0}, {32'hdb135345, 96'h0}};
        vecs[1] = '{{32'h8e4da1bc, 32'h9fdc589d, 32'hd5d5d7d6, 32'h4d7ebdf8},
                    {32'hdb135345, 32'hf20a225c, 32'hd4d4d4d5, 32'h2d26314c}};
        vecs[2] = '{{4{32'h01010101}}, {4{32'h01010101}}};
        vecs[3] = '{{4{32'hc6c6c6c6}}, {4{32'hc6c6c6c6}}};
        vecs[4] = '{{96'h0, 32'h8e4da1bc}, {96'h0, 32'hdb135345}};
        vecs[5] = '{{32'h01000000, 32'h00800000, 64'h0}, {32'h0e090d0b, 32'hf741ecda, 64'h0}};
        vecs[6] = '{128'h0, 128'h0};

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_state  = '0;
        out_ready = 1'b0;
`ifdef IMC_FWD_MODE_EN
        fwd       = 1'b0;
`endif
        step();
        step();
        rst = 1'b0;
        check("reset out_valid", 128'(out_valid), 128'(0));
        check("reset out_state", out_state, 128'h0);
        check("reset in_ready", 128'(in_ready), 128'(1));

        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("early out_ready", 128'({out_valid, in_ready}), 128'(2'b01));

        for (int i = 0; i < 7; i++) begin
            run_block($sformatf("vec%0d", i), vecs[i].din, vecs[i].dout);
        end

        // Backpressure: DONE held for 10 cycles.
        in_valid = 1'b1;
        in_state = vecs[1].din;
        step();
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) step();
        held = out_state;
        check("bp data", held, vecs[1].dout);
        for (int i = 0; i < 10; i++) begin
            step();
            check($sformatf("bp hold %0d", i),
                  {out_state[127:2], out_valid, in_ready}, {held[127:2], 2'b10});
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("bp release", 128'({out_valid, in_ready}), 128'(2'b01));

        // Reset while column 2 is pending.
        in_valid = 1'b1;
        in_state = vecs[1].din;
        step();
        in_valid = 1'b0;
        step();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("midrst out_valid", 128'(out_valid), 128'(0));
        check("midrst out_state", out_state, 128'h0);
        check("midrst in_ready", 128'(in_ready), 128'(1));
        run_block("post-rst", vecs[0].din, vecs[0].dout);

        // in_valid held high across two blocks with out_ready always high.
        acc_n     = 0;
        in_valid  = 1'b1;
        in_state  = vecs[1].din;
        out_ready = 1'b1;
        for (int cyc = 0; cyc < 40; cyc++) begin
            if (in_valid && in_ready && acc_n < 2) begin
                acc_cyc[acc_n] = cyc;
                acc_n++;
            end
            if (out_valid && out_ready) res.push_back(out_state);
            step();
            if (acc_n == 1) in_state = vecs[5].din;
            if (acc_n == 2) in_valid = 1'b0;
        end
        out_ready = 1'b0;
        check("b2b accepts", 128'(acc_n), 128'(2));
        check("b2b spacing", 128'(acc_cyc[1] - acc_cyc[0]), 128'(6));
        check("b2b results", 128'(res.size()), 128'(2));
        if (res.size() == 2) begin
            check("b2b res0", res[0], vecs[1].dout);
            check("b2b res1", res[1], vecs[5].dout);
        end

`ifdef IMC_FWD_MODE_EN
        fwd = 1'b1;
        run_block("fwd", {32'hdb135345, 96'h0}, {32'h8e4da1bc, 96'h0});
        fwd = 1'b0;
        run_block("fwd rtrip", {32'h8e4da1bc, 96'h0}, {32'hdb135345, 96'h0});
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
